pipeline_hazard_controller: RTL and testbench

- Central sequencer for the five-stage pipeline (fetch, decode, execute, memory, write-back).
- Drives PC write-enable and PC source select.
- Drives hold (enable) and bubble (flush) controls for the FD, DE, EM and MW pipeline registers.
- Resolves four event types: load-use hazards, taken branches, two-cycle 32-bit stack accesses (PC push/pop) on the 16-bit data memory, and interrupt entry.

---
 rtl/pipeline_hazard_controller_pkg.sv | 17 +
 rtl/pipeline_hazard_controller_hazard_compare.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared constants for the pipeline hazard controller.
// FSM state codes, PC source selects and the default drain length.
package pipeline_hazard_controller_pkg;

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_PUSH_LO = 3'd2;
    localparam logic [2:0] ST_PUSH_HI = 3'd3;
    localparam logic [2:0] ST_VECTOR  = 3'd4;

    localparam logic [1:0] PCSEL_INC = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_VEC = 2'd2;

    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_compare.sv
// Combinational load-use detector: a load in DE whose destination
// matches a source register that decode actually reads.
module hazard_compare
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] dst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             use1,
    input  logic             use2,
    output logic             hazard
);

    logic hit1;
    logic hit2;

    assign hit1   = use1 && (src1 == dst);
    assign hit2   = use2 && (src2 == dst);
    assign hazard = mem_read && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central sequencer: PC control, pipeline hold/bubble, two-cycle
// stack accesses and interrupt entry for the five-stage pipeline.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de_mem_read,
    input  logic [REG_W-1:0] de_dst,
    input  logic [REG_W-1:0] fd_src1,
    input  logic [REG_W-1:0] fd_src2,
    input  logic             fd_use1,
    input  logic             fd_use2,
    input  logic             ex_branch_taken,
    input  logic             em_mem32,
    input  logic             int_req,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             mw_flush,
    output logic             mem_half,
    output logic             int_push,
    output logic             int_ack
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    logic [2:0]       state;
    logic [2:0]       state_n;
    logic             mem_hi;
    logic             mem_hi_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             load_use;
    logic             first_half;
    logic             mem_ok;

    hazard_compare #(
        .REG_W(REG_W)
    ) u_cmp (
        .mem_read(de_mem_read),
        .dst     (de_dst),
        .src1    (fd_src1),
        .src2    (fd_src2),
        .use1    (fd_use1),
        .use2    (fd_use2),
        .hazard  (load_use)
    );

    // EM only carries real traffic while running or draining
    assign mem_ok     = (state == ST_RUN) || (state == ST_DRAIN);
    assign first_half = mem_ok && em_mem32 && !mem_hi;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mem_hi_n = first_half;
        pc_write = 1'b1;
        pc_sel   = PCSEL_INC;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        mw_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        mw_flush = 1'b0;
        mem_half = mem_hi;
        int_push = 1'b0;
        int_ack  = 1'b0;
        unique case (state)
            ST_RUN, ST_DRAIN: begin
                if (state == ST_DRAIN) begin
                    pc_write = 1'b0;
                    fd_flush = 1'b1;
                end
                if (first_half) begin
                    pc_write = 1'b0;
                    fd_en    = 1'b0;
                    de_en    = 1'b0;
                    em_en    = 1'b0;
                    fd_flush = 1'b0;
                    mw_flush = 1'b1;
                end else begin
                    if (ex_branch_taken) begin
                        pc_sel   = PCSEL_BR;
                        pc_write = 1'b1;
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write = 1'b0;
                        fd_en    = 1'b0;
                        fd_flush = 1'b0;
                        de_flush = 1'b1;
                    end else if (state == ST_RUN && int_req) begin
                        state_n = ST_DRAIN;
                        cnt_n   = CNT_W'(DRAIN_CYCLES);
                    end
                    if (state == ST_DRAIN) begin
                        cnt_n = cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state_n = ST_PUSH_LO;
                        end
                    end
                end
            end
            ST_PUSH_LO: begin
                pc_write = 1'b0;
                fd_flush = 1'b1;
                int_push = 1'b1;
                mem_half = 1'b0;
                state_n  = ST_PUSH_HI;
            end
            ST_PUSH_HI: begin
                pc_write = 1'b0;
                fd_flush = 1'b1;
                int_push = 1'b1;
                mem_half = 1'b1;
                state_n  = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_sel   = PCSEL_VEC;
                fd_flush = 1'b1;
                int_ack  = 1'b1;
                state_n  = ST_RUN;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
        // Reset overrides combinationally so outputs react at once
        if (!reset) begin
            pc_write = 1'b0;
            pc_sel   = PCSEL_INC;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            mw_flush = 1'b1;
            mem_half = 1'b0;
            int_push = 1'b0;
            int_ack  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            mem_hi <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            mem_hi <= mem_hi_n;
            cnt    <= cnt_n;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed literal checks, then
// random stimulus compared each cycle against a queue-based model.
module tb_pipeline_hazard_controller;

    localparam int REG_W = 4;
    localparam int DRAIN = 3;

    // {pc_write, pc_sel, fd/de/em/mw_en, fd/de/mw_flush, half, push, ack}
    localparam logic [12:0] O_RST = 13'b0_00_0000_111_000;
    localparam logic [12:0] O_DEF = 13'b1_00_1111_000_000;
    localparam logic [12:0] O_LU  = 13'b0_00_0111_010_000;
    localparam logic [12:0] O_BR  = 13'b1_01_1111_110_000;
    localparam logic [12:0] O_M1  = 13'b0_00_0001_001_000;
    localparam logic [12:0] O_M2  = 13'b1_00_1111_000_100;
    localparam logic [12:0] O_M2B = 13'b1_01_1111_110_100;
    localparam logic [12:0] O_DR  = 13'b0_00_1111_100_000;
    localparam logic [12:0] O_DRH = 13'b0_00_1111_100_100;
    localparam logic [12:0] O_PL  = 13'b0_00_1111_100_010;
    localparam logic [12:0] O_PH  = 13'b0_00_1111_100_110;
    localparam logic [12:0] O_VEC = 13'b1_10_1111_100_001;

    logic             clk = 1'b0;
    logic             reset;
    logic             de_mem_read;
    logic [REG_W-1:0] de_dst;
    logic [REG_W-1:0] fd_src1;
    logic [REG_W-1:0] fd_src2;
    logic             fd_use1;
    logic             fd_use2;
    logic             ex_branch_taken;
    logic             em_mem32;
    logic             int_req;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             mw_flush;
    logic             mem_half;
    logic             int_push;
    logic             int_ack;
    logic [12:0]      outs;

    int total = 0;
    int bad = 0;
    int ack_seen = 0;

    // Interrupt sequence as a queue of phases: 1 drain, 2 lo, 3 hi, 4 vec
    int q[$];
    bit hi_m = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_W       (REG_W),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .de_mem_read    (de_mem_read),
        .de_dst         (de_dst),
        .fd_src1        (fd_src1),
        .fd_src2        (fd_src2),
        .fd_use1        (fd_use1),
        .fd_use2        (fd_use2),
        .ex_branch_taken(ex_branch_taken),
        .em_mem32       (em_mem32),
        .int_req        (int_req),
        .pc_write       (pc_write),
        .pc_sel         (pc_sel),
        .fd_en          (fd_en),
        .de_en          (de_en),
        .em_en          (em_en),
        .mw_en          (mw_en),
        .fd_flush       (fd_flush),
        .de_flush       (de_flush),
        .mw_flush       (mw_flush),
        .mem_half       (mem_half),
        .int_push       (int_push),
        .int_ack        (int_ack)
    );

    assign outs = {pc_write, pc_sel, fd_en, de_en, em_en, mw_en,
                   fd_flush, de_flush, mw_flush, mem_half, int_push,
                   int_ack};

    function automatic bit lu_now();
        bit h1;
        bit h2;
        h1 = fd_use1 && (fd_src1 == de_dst);
        h2 = fd_use2 && (fd_src2 == de_dst);
        return de_mem_read && (h1 || h2);
    endfunction

    function automatic bit stall_now(int ph, bit hi);
        return (ph <= 1) && em_mem32 && !hi;
    endfunction

    function automatic logic [12:0] model_out(int ph, bit hi);
        bit pw, fe, de, ee, me, ff, df, mf, mh, ip, ia;
        logic [1:0] ps;
        if (!reset) return O_RST;
        pw = 1; ps = 2'd0; fe = 1; de = 1; ee = 1; me = 1;
        ff = 0; df = 0; mf = 0; mh = hi; ip = 0; ia = 0;
        case (ph)
            2: begin pw = 0; ff = 1; ip = 1; mh = 0; end
            3: begin pw = 0; ff = 1; ip = 1; mh = 1; end
            4: begin ps = 2'd2; ff = 1; ia = 1; end
            default: begin
                if (ph == 1) begin pw = 0; ff = 1; end
                if (stall_now(ph, hi)) begin
                    pw = 0; fe = 0; de = 0; ee = 0; ff = 0; mf = 1;
                end else if (ex_branch_taken) begin
                    ps = 2'd1; pw = 1; ff = 1; df = 1;
                end else if (lu_now()) begin
                    pw = 0; fe = 0; ff = 0; df = 1;
                end
            end
        endcase
        return {pw, ps, fe, de, ee, me, ff, df, mf, mh, ip, ia};
    endfunction

    task automatic model_advance(int ph);
        bit st;
        st = stall_now(ph, hi_m);
        if (!reset) begin
            q.delete();
            hi_m = 1'b0;
        end else begin
            hi_m = st;
            if (ph == 0) begin
                if (!st && !ex_branch_taken && !lu_now() && int_req) begin
                    for (int i = 0; i < DRAIN; i++) q.push_back(1);
                    q.push_back(2);
                    q.push_back(3);
                    q.push_back(4);
                end
            end else if (!(ph == 1 && st)) begin
                void'(q.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        begin : cmp
            int ph;
            logic [12:0] want;
            ph = (q.size() == 0) ? 0 : q[0];
            want = model_out(ph, hi_m);
            total++;
            if (outs !== want) begin
                bad++;
                $display("FAIL model t=%0t got=%b want=%b", $time,
                         outs, want);
            end
            if (int_ack === 1'b1) ack_seen++;
            model_advance(ph);
        end
    end

    task automatic chk(input string nm, input logic [12:0] got,
                       input logic [12:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic idle();
        reset = 1'b1;
        de_mem_read = 1'b0;
        de_dst = '0;
        fd_src1 = '0;
        fd_src2 = '0;
        fd_use1 = 1'b0;
        fd_use2 = 1'b0;
        ex_branch_taken = 1'b0;
        em_mem32 = 1'b0;
        int_req = 1'b0;
    endtask

    task automatic step(input string nm, input logic [12:0] want);
        #3;
        chk(nm, outs, want);
        @(negedge clk);
    endtask

    initial begin
        int snap;
        idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step("reset", O_RST);
        step("reset2", O_RST);
        idle();
        step("default", O_DEF);

        de_mem_read = 1'b1; de_dst = 4'd3;
        fd_src1 = 4'd3; fd_use1 = 1'b1; fd_src2 = 4'd5;
        step("load_use", O_LU);
        idle();
        step("load_use_after", O_DEF);
        de_mem_read = 1'b1; de_dst = 4'd3; fd_src1 = 4'd3;
        step("load_nouse", O_DEF);

        idle(); ex_branch_taken = 1'b1;
        step("branch", O_BR);
        idle();
        step("branch_after", O_DEF);

        em_mem32 = 1'b1;
        step("mem32_lo", O_M1);
        step("mem32_hi", O_M2);
        ex_branch_taken = 1'b1;
        step("mem32br_lo", O_M1);
        step("mem32br_hi", O_M2B);
        idle();
        step("mem32_after", O_DEF);

        snap = ack_seen;
        int_req = 1'b1;
        step("irq_req", O_DEF);
        idle();
        step("drain1", O_DR);
        step("drain2", O_DR);
        step("drain3", O_DR);
        step("push_lo", O_PL);
        step("push_hi", O_PH);
        step("vector", O_VEC);
        step("irq_back", O_DEF);
        chk_int("ack_once", ack_seen - snap, 1);

        snap = ack_seen;
        int_req = 1'b1;
        step("irq2_req", O_DEF);
        idle();
        step("sd_drain1", O_DR);
        em_mem32 = 1'b1;
        step("sd_stall", O_M1);
        idle();
        step("sd_drain2", O_DRH);
        step("sd_drain3", O_DR);
        step("sd_push_lo", O_PL);
        step("sd_push_hi", O_PH);
        step("sd_vector", O_VEC);
        chk_int("sd_ack_once", ack_seen - snap, 1);

        idle();
        step("gap", O_DEF);
        int_req = 1'b1;
        step("irq3_req", O_DEF);
        idle();
        step("r_drain1", O_DR);
        step("r_drain2", O_DR);
        step("r_drain3", O_DR);
        step("r_push_lo", O_PL);
        snap = ack_seen;
        reset = 1'b0;
        step("rst_in_push_hi", O_RST);
        idle();
        step("rst_release", O_DEF);
        for (int i = 0; i < 8; i++) step("rst_quiet", O_DEF);
        chk_int("rst_no_ack", ack_seen - snap, 0);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            de_mem_read = ($urandom_range(0, 2) == 0);
            de_dst = REG_W'($urandom_range(0, 3));
            fd_src1 = REG_W'($urandom_range(0, 3));
            fd_src2 = REG_W'($urandom_range(0, 3));
            fd_use1 = $urandom_range(0, 1) != 0;
            fd_use2 = $urandom_range(0, 1) != 0;
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            em_mem32 = ($urandom_range(0, 6) == 0);
            int_req = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
